// File: rtl/pipelined_prefix_adder_if.sv
// Valid/ready operand and result bundle for pipelined_prefix_adder.
// The out_ovf wire exists only when PPA_OVERFLOW_EN is defined.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef PPA_OVERFLOW_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef PPA_OVERFLOW_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef PPA_OVERFLOW_EN
        , output out_ovf
`endif
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// Define PPA_OVERFLOW_EN to add the registered signed-overflow output out_ovf.
module pipelined_prefix_adder #(
    parameter int WIDTH     = 128,
    parameter int REG_EVERY = 2
) (
    input logic clk,
    input logic rst_n,
    pipelined_prefix_adder_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);
    // Prefix stages after operand prep; the last one lands in the output register.
    localparam int NSTG  = (LOG2W + REG_EVERY - 1) / REG_EVERY;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    // Applies prefix levels lo..hi-1 to a (generate, propagate) vector pair.
    function automatic gp_t prefix_levels(gp_t x, int lo, int hi);
        gp_t y;
        for (int k = 0; k < LOG2W; k++) begin
            if (k >= lo && k < hi) begin
                y = x;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i >= (1 << k)) begin
                        y.g[i] = x.g[i] | (x.p[i] & x.g[i - (1 << k)]);
                        y.p[i] = x.p[i] & x.p[i - (1 << k)];
                    end
                end
                x = y;
            end
        end
        return x;
    endfunction

    function automatic logic [WIDTH-1:0] prefix_g(gp_t x, int lo, int hi);
        gp_t y;
        y = prefix_levels(x, lo, hi);
        return y.g;
    endfunction

    logic             advance;
    logic             accept;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;

    assign advance      = !out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & advance;
    assign bus.in_ready = advance;

    for (genvar s = 0; s < NSTG; s++) begin : stg
        logic             v;
        gp_t              gp;
        logic [WIDTH-1:0] pr;
        logic             c0;

        if (s == 0) begin : prep
            logic [WIDTH-1:0] bx;
            logic [WIDTH-1:0] gi;
            logic [WIDTH-1:0] pi;
            logic             ci;

            // NOTE: always_comb uses blocking '=' and assigns every variable on every pass, so no latch is inferred.
            always_comb begin
                bx    = bus.in_sub ? ~bus.in_b : bus.in_b;
                ci    = bus.in_cin ^ bus.in_sub;
                pi    = bus.in_a ^ bx;
                gi    = bus.in_a & bx;
                // Carry-in folded into bit 0 so the tree produces true carries.
                gi[0] = gi[0] | (pi[0] & ci);
            end

            // NOTE: data registers are reset along with the valids so a flushed pipe holds all zeros.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v  <= 1'b0;
                    gp <= '0;
                    pr <= '0;
                    c0 <= 1'b0;
                end else if (advance) begin
                    v  <= accept;
                    gp <= '{g: gi, p: pi};
                    pr <= pi;
                    c0 <= ci;
                end
            end
        end else begin : pfx
            gp_t nxt;
            assign nxt = prefix_levels(stg[s-1].gp, (s - 1) * REG_EVERY, s * REG_EVERY);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v  <= 1'b0;
                    gp <= '0;
                    pr <= '0;
                    c0 <= 1'b0;
                end else if (advance) begin
                    v  <= stg[s-1].v;
                    gp <= nxt;
                    pr <= stg[s-1].pr;
                    c0 <= stg[s-1].c0;
                end
            end
        end
    end

    logic [WIDTH-1:0] fin_g;
    logic [WIDTH-1:0] carry_into;
    logic [WIDTH-1:0] sum_c;

    assign fin_g      = prefix_g(stg[NSTG-1].gp, (NSTG - 1) * REG_EVERY, LOG2W);
    assign carry_into = {fin_g[WIDTH-2:0], stg[NSTG-1].c0};
    assign sum_c      = stg[NSTG-1].pr ^ carry_into;

    // NOTE: sequential state uses non-blocking '<=' so all stages shift on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
        end else if (advance) begin
            out_valid_q <= stg[NSTG-1].v;
            out_sum_q   <= sum_c;
            out_cout_q  <= fin_g[WIDTH-1];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;

`ifdef PPA_OVERFLOW_EN
    logic out_ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_ovf_q <= 1'b0;
        end else if (advance) begin
            out_ovf_q <= carry_into[WIDTH-1] ^ fin_g[WIDTH-1];
        end
    end

    assign bus.out_ovf = out_ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder: 128-bit/REG_EVERY=2 and 8-bit/REG_EVERY=1 instances
// against an arithmetic reference model; overflow checks are active when PPA_OVERFLOW_EN is defined.
module tb_pipelined_prefix_adder;
    localparam int W   = 128;
    localparam int RE  = 2;
    localparam int LAT = 5;
    localparam int SW  = 8;
    localparam int SRE = 1;

    typedef struct { logic [129:0] a; logic [129:0] b; logic cin; logic sub; } beat_t;
    typedef struct { logic [129:0] sum; logic cout; logic ovf; } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;
    int   sn_out = 0;
    bit   drv_en = 1'b0;

    beat_t src_q[$];
    beat_t ssrc_q[$];
    exp_t  exp_q[$];
    exp_t  sexp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_prefix_adder_if #(.WIDTH(W))  bus  ();
    pipelined_prefix_adder_if #(.WIDTH(SW)) sbus ();

    pipelined_prefix_adder #(.WIDTH(W), .REG_EVERY(RE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    pipelined_prefix_adder #(.WIDTH(SW), .REG_EVERY(SRE)) sdut (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    // Reference: plain wide arithmetic on the operands, reduced to a w-bit result.
    function automatic exp_t model(beat_t x, int w);
        exp_t m;
        logic [129:0] mask, s;
        logic signed [129:0] sa, sb, sr, lim, ci;
        mask = (130'd1 << w) - 130'd1;
        if (!x.sub) begin
            s = x.a + x.b + {129'd0, x.cin};
            m.cout = s[w];
        end else begin
            s = x.a - x.b - {129'd0, x.cin};
            m.cout = (x.a >= x.b + {129'd0, x.cin});
        end
        m.sum = s & mask;
        sa  = x.a[w-1] ? $signed(x.a | ~mask) : $signed(x.a);
        sb  = x.b[w-1] ? $signed(x.b | ~mask) : $signed(x.b);
        ci  = $signed({129'd0, x.cin});
        sr  = x.sub ? (sa - sb - ci) : (sa + sb + ci);
        lim = $signed(130'd1 << (w - 1));
        m.ovf = (sr >= lim) || (sr < -lim);
        return m;
    endfunction

    function automatic beat_t rand_beat(int w);
        beat_t x;
        logic [129:0] mask;
        mask  = (130'd1 << w) - 130'd1;
        x.a   = {2'b0, $urandom, $urandom, $urandom, $urandom} & mask;
        x.b   = {2'b0, $urandom, $urandom, $urandom, $urandom} & mask;
        if ($urandom_range(0, 7) == 0) x.a = mask;
        if ($urandom_range(0, 7) == 0) x.b = 130'd1;
        x.cin = 1'($urandom);
        x.sub = 1'($urandom);
        return x;
    endfunction

    // Sources present the head of their queue until it is accepted.
    always @(posedge clk) begin
        #1;
        if (drv_en) begin
            bus.in_valid = (src_q.size() != 0);
            if (src_q.size() != 0) begin
                bus.in_a   = src_q[0].a[W-1:0];
                bus.in_b   = src_q[0].b[W-1:0];
                bus.in_cin = src_q[0].cin;
                bus.in_sub = src_q[0].sub;
            end
        end
        sbus.in_valid = (ssrc_q.size() != 0);
        if (ssrc_q.size() != 0) begin
            sbus.in_a   = ssrc_q[0].a[SW-1:0];
            sbus.in_b   = ssrc_q[0].b[SW-1:0];
            sbus.in_cin = ssrc_q[0].cin;
            sbus.in_sub = ssrc_q[0].sub;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready && src_q.size() != 0)
                exp_q.push_back(model(src_q.pop_front(), W));
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL big_spurious: got sum=%h cout=%b, want no result", bus.out_sum, bus.out_cout);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_sum !== e.sum[W-1:0] || bus.out_cout !== e.cout) begin
                        bad++;
                        $display("FAIL big_result: got sum=%h cout=%b, want sum=%h cout=%b",
                                 bus.out_sum, bus.out_cout, e.sum[W-1:0], e.cout);
                    end
`ifdef PPA_OVERFLOW_EN
                    total++;
                    if (bus.out_ovf !== e.ovf) begin
                        bad++;
                        $display("FAIL big_ovf: got %b, want %b", bus.out_ovf, e.ovf);
                    end
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sexp_q.delete();
        end else begin
            if (sbus.in_valid && sbus.in_ready && ssrc_q.size() != 0)
                sexp_q.push_back(model(ssrc_q.pop_front(), SW));
            if (sbus.out_valid && sbus.out_ready) begin
                sn_out++;
                total++;
                if (sexp_q.size() == 0) begin
                    bad++;
                    $display("FAIL small_spurious: got sum=%h, want no result", sbus.out_sum);
                end else begin
                    e = sexp_q.pop_front();
                    if (sbus.out_sum !== e.sum[SW-1:0] || sbus.out_cout !== e.cout) begin
                        bad++;
                        $display("FAIL small_result: got sum=%h cout=%b, want sum=%h cout=%b",
                                 sbus.out_sum, sbus.out_cout, e.sum[SW-1:0], e.cout);
                    end
`ifdef PPA_OVERFLOW_EN
                    total++;
                    if (sbus.out_ovf !== e.ovf) begin
                        bad++;
                        $display("FAIL small_ovf: got %b, want %b", sbus.out_ovf, e.ovf);
                    end
`endif
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (src_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d beats outstanding, want 0", name, src_q.size() + exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                           output logic [W-1:0] sum, output logic cout, output logic ovf, output int lat);
        beat_t x;
        int n;
        int c_acc;
        x.a = {2'b0, a};
        x.b = {2'b0, b};
        x.cin = cin;
        x.sub = sub;
        bus.out_ready = 1'b1;
        src_q.push_back(x);
        n = 0;
        while (src_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        c_acc = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.out_valid !== 1'b1 && n < 50);
        lat  = cyc - c_acc;
        sum  = bus.out_sum;
        cout = bus.out_cout;
`ifdef PPA_OVERFLOW_EN
        ovf  = bus.out_ovf;
`else
        ovf  = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen;
        drv_en = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = '1;
        bus.in_b = 128'd1;
        bus.in_cin = 1'b0;
        bus.in_sub = 1'b0;
        bus.out_ready = 1'b1;
        sbus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, want 0", bus.out_valid); end
            total++;
            if (bus.out_sum !== '0) begin bad++; $display("FAIL reset_sum: got %h, want 0", bus.out_sum); end
            total++;
            if (bus.out_cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b, want 0", bus.out_cout); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready); end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL reset_emitted: got %0d results, want 0", seen); end
        @(posedge clk);
        #1;
        drv_en = 1'b1;
    endtask

    task automatic test_carry();
        logic [W-1:0] s;
        logic c, o;
        int lat;
        run_one('1, 128'd1, 1'b0, 1'b0, s, c, o, lat);
        total++;
        if (lat != LAT) begin bad++; $display("FAIL carry_latency: got %0d, want %0d", lat, LAT); end
        total++;
        if (s !== '0 || c !== 1'b1) begin bad++; $display("FAIL carry_ripple: got sum=%h cout=%b, want 0/1", s, c); end
        run_one('0, '0, 1'b1, 1'b0, s, c, o, lat);
        total++;
        if (s !== 128'd1 || c !== 1'b0) begin bad++; $display("FAIL carry_cin: got sum=%h cout=%b, want 1/0", s, c); end
    endtask

    task automatic test_sub();
        logic [W-1:0] s, want;
        logic c, o;
        int lat;
        want = ~128'd1;
        run_one(128'd5, 128'd7, 1'b0, 1'b1, s, c, o, lat);
        total++;
        if (s !== want || c !== 1'b0) begin bad++; $display("FAIL sub_neg: got sum=%h cout=%b, want %h/0", s, c, want); end
        run_one(128'd7, 128'd5, 1'b0, 1'b1, s, c, o, lat);
        total++;
        if (s !== 128'd2 || c !== 1'b1) begin bad++; $display("FAIL sub_pos: got sum=%h cout=%b, want 2/1", s, c); end
        run_one(128'd7, 128'd5, 1'b1, 1'b1, s, c, o, lat);
        total++;
        if (s !== 128'd1) begin bad++; $display("FAIL sub_borrow: got sum=%h, want 1", s); end
    endtask

    task automatic test_back_to_back();
        int base, stalls;
        base = n_out;
        stalls = 0;
        for (int i = 0; i < 16; i++) src_q.push_back(rand_beat(W));
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = !(i >= 3 && i <= 8);
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                stalls++;
                total++;
                if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready: got %b, want 0", bus.in_ready); end
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        wait_drain("b2b", 100);
        total++;
        if (stalls == 0) begin bad++; $display("FAIL b2b_no_stall: got 0 stalled cycles, want >0"); end
        total++;
        if (n_out - base != 16) begin bad++; $display("FAIL b2b_count: got %0d, want 16", n_out - base); end
    endtask

    task automatic test_toggle();
        int base;
        base = n_out;
        for (int i = 0; i < 24; i++) src_q.push_back(rand_beat(W));
        for (int i = 0; i < 80; i++) begin
            bus.out_ready = (i % 2 == 1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        wait_drain("toggle", 100);
        total++;
        if (n_out - base != 24) begin bad++; $display("FAIL toggle_count: got %0d, want 24", n_out - base); end
    endtask

    task automatic test_flush();
        int base, n;
        base = n_out;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) src_q.push_back(rand_beat(W));
        n = 0;
        while (src_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b, want 0", bus.out_valid); end
        repeat (12) @(negedge clk);
        total++;
        if (n_out != base) begin bad++; $display("FAIL flush_emitted: got %0d results, want 0", n_out - base); end
        @(posedge clk);
        #1;
    endtask

`ifdef PPA_OVERFLOW_EN
    task automatic test_overflow();
        logic [W-1:0] s, a;
        logic c, o;
        int lat;
        a = {1'b0, {(W-1){1'b1}}};
        run_one(a, 128'd1, 1'b0, 1'b0, s, c, o, lat);
        total++;
        if (o !== 1'b1 || c !== 1'b0) begin bad++; $display("FAIL ovf_pos: got ovf=%b cout=%b, want 1/0", o, c); end
        a = {1'b1, {(W-1){1'b0}}};
        run_one(a, a, 1'b0, 1'b0, s, c, o, lat);
        total++;
        if (s !== '0 || o !== 1'b1 || c !== 1'b1) begin
            bad++;
            $display("FAIL ovf_neg: got sum=%h ovf=%b cout=%b, want 0/1/1", s, o, c);
        end
    endtask
`endif

    task automatic test_small_width();
        int base, n;
        beat_t x;
        base = sn_out;
        x.a = 130'd255; x.b = 130'd1; x.cin = 1'b0; x.sub = 1'b0;
        ssrc_q.push_back(x);
        x.a = 130'd0;   x.b = 130'd1; x.cin = 1'b0; x.sub = 1'b1;
        ssrc_q.push_back(x);
        for (int i = 0; i < 2000; i++) ssrc_q.push_back(rand_beat(SW));
        n = 0;
        while ((ssrc_q.size() != 0 || sexp_q.size() != 0) && n < 20000) begin
            sbus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            n++;
        end
        sbus.out_ready = 1'b1;
        total++;
        if (sn_out - base != 2002) begin bad++; $display("FAIL small_count: got %0d, want 2002", sn_out - base); end
    endtask

    initial begin
        sbus.in_valid = 1'b0;
        sbus.in_a = '0;
        sbus.in_b = '0;
        sbus.in_cin = 1'b0;
        sbus.in_sub = 1'b0;
        test_reset();
        test_carry();
        test_sub();
        test_back_to_back();
        test_toggle();
        test_flush();
`ifdef PPA_OVERFLOW_EN
        test_overflow();
`endif
        test_small_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
